// File: rtl/pong_ai_paddle_driver.sv
// pong_ai_paddle_driver
// Computer opponent for the right-hand Pong paddle. Produces up/down button
// requests from ball position/direction and the fed-back paddle_y, with a
// reaction delay, dead zone with hysteresis and return-to-centre behaviour.
// Optional aim error: define PONG_AI_AIM_ERROR_EN to add an LFSR-derived
// per-rally offset (-2..+1) to the ball target.
//
// state  | meaning
// IDLE   | no rally, outputs idle
// RETURN | ball moving away, drift toward board centre
// REACT  | ball turned toward us, waiting out the reaction delay
// TRACK  | chasing the ball target
// HOLD   | on target, idle until the error exceeds the hysteresis band
module pong_ai_paddle_driver #(
  parameter int PADDLE_HEIGHT = 6,
  parameter int GAME_HEIGHT   = 30,
  parameter int REACT_TICKS   = 6250000,
  parameter int DEAD_ZONE     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_active,
  input  logic [5:0] ball_y,
  input  logic       ball_dir_x,
  input  logic [5:0] paddle_y,
  output logic       up,
  output logic       down,
  output logic [2:0] ai_state
);

  localparam int MAX_Y  = GAME_HEIGHT - PADDLE_HEIGHT - 1;
  localparam int CENTER = (GAME_HEIGHT - PADDLE_HEIGHT) / 2;
  localparam int CW     = $clog2(REACT_TICKS + 1);

  localparam logic signed [6:0] HALF7   = 7'(PADDLE_HEIGHT / 2);
  localparam logic signed [6:0] MAX_Y7  = 7'(MAX_Y);
  localparam logic signed [6:0] CENTER7 = 7'(CENTER);
  localparam logic signed [6:0] DZ7     = 7'(DEAD_ZONE);
  localparam logic signed [6:0] HYST7   = 7'(DEAD_ZONE + 1);
  localparam logic [5:0]        MAX_Y6  = 6'(MAX_Y);
  localparam logic [CW-1:0]     CNT_END = CW'(REACT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RETURN = 3'd1,
    S_REACT  = 3'd2,
    S_TRACK  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t            state;
  logic [CW-1:0]     react_cnt;
  logic signed [6:0] offset;
  logic signed [6:0] t_raw, target, target_sel, diff, mag;
  logic              in_dead, out_hyst, drive, req_up, req_dn, enter_react;

  assign enter_react = game_active && ball_dir_x &&
                       (state == S_IDLE || state == S_RETURN);

`ifdef PONG_AI_AIM_ERROR_EN
  logic [7:0] lfsr;
  logic [1:0] aim;

  // Free-running LFSR; a fresh aim offset is captured each time REACT is entered
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 8'hA5;
      aim  <= 2'b00;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (enter_react) aim <= lfsr[1:0];
    end
  end

  assign offset = {{5{aim[1]}}, aim};
`else
  assign offset = 7'sd0;
`endif

  // Clamped ball target, error to the selected target and the request it implies
  always_comb begin
    t_raw = $signed({1'b0, ball_y}) - HALF7 + offset;
    if (t_raw < 0)           target = 7'sd0;
    else if (t_raw > MAX_Y7) target = MAX_Y7;
    else                     target = t_raw;
    target_sel = (state == S_RETURN) ? CENTER7 : target;
    diff       = target_sel - $signed({1'b0, paddle_y});
    mag        = (diff < 0) ? -diff : diff;
    in_dead    = (mag <= DZ7);
    out_hyst   = (mag > HYST7);
    drive      = game_active && !in_dead &&
                 ((state == S_RETURN && !ball_dir_x) || (state == S_TRACK && ball_dir_x));
    req_up     = drive && (diff < 0) && (paddle_y != 6'd0);
    req_dn     = drive && (diff > 0) && (paddle_y < MAX_Y6);
  end

  // State machine, reaction counter and registered requests with a reversal gap
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      react_cnt <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
    end else begin
      up        <= req_up && !down;
      down      <= req_dn && !up;
      react_cnt <= '0;
      if (!game_active) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE:   state <= ball_dir_x ? S_REACT : S_RETURN;
          S_RETURN: if (ball_dir_x) state <= S_REACT;
          S_REACT: begin
            if (!ball_dir_x)             state <= S_RETURN;
            else if (react_cnt == CNT_END) state <= S_TRACK;
            else                         react_cnt <= react_cnt + CW'(1);
          end
          S_TRACK: begin
            if (!ball_dir_x)  state <= S_RETURN;
            else if (in_dead) state <= S_HOLD;
          end
          S_HOLD: begin
            if (!ball_dir_x)   state <= S_RETURN;
            else if (out_hyst) state <= S_TRACK;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign ai_state = state;

endmodule

// File: tb/tb_pong_ai_paddle_driver.sv
// Bench for pong_ai_paddle_driver: directed walk through the main behaviours
// followed by random play, every cycle compared against a behavioural model.
module tb_pong_ai_paddle_driver;

  localparam int PH   = 6;
  localparam int GH   = 30;
  localparam int RT   = 4;
  localparam int DZ   = 1;
  localparam int MAXY = GH - PH - 1;
  localparam int CEN  = (GH - PH) / 2;

  localparam int IDLE = 0, RET = 1, REA = 2, TRK = 3, HLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       game_active = 1'b0;
  logic [5:0] ball_y = '0;
  logic       ball_dir_x = 1'b0;
  logic [5:0] paddle_y = '0;
  logic       up, down;
  logic [2:0] ai_state;

  int total = 0;
  int bad   = 0;

  int m_state = IDLE, m_cnt = 0, m_up = 0, m_dn = 0, m_lf = 'hA5, m_off = 0;

  pong_ai_paddle_driver #(
    .PADDLE_HEIGHT(PH), .GAME_HEIGHT(GH), .REACT_TICKS(RT), .DEAD_ZONE(DZ)
  ) dut (
    .clock(clock), .reset(reset), .game_active(game_active), .ball_y(ball_y),
    .ball_dir_x(ball_dir_x), .paddle_y(paddle_y), .up(up), .down(down),
    .ai_state(ai_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Directed expectations assume no aim offset
  task automatic xchk(input string tag, input int got, input int exp);
`ifndef PONG_AI_AIM_ERROR_EN
    chk(tag, got, exp);
`endif
  endtask

  // Behavioural reference: one clock of the paddle AI, from the rules
  task automatic model_step();
    int by, py, t, tgt, sel, d, ad, ns, nc, v;
    bit ga, bd, drive, wu, wd;
    if (reset) begin
      m_state = IDLE; m_cnt = 0; m_up = 0; m_dn = 0; m_lf = 'hA5; m_off = 0;
      return;
    end
    by = int'(ball_y); py = int'(paddle_y); ga = game_active; bd = ball_dir_x;
    t   = by - PH / 2 + m_off;
    tgt = (t < 0) ? 0 : ((t > MAXY) ? MAXY : t);
    sel = (m_state == RET) ? CEN : tgt;
    d   = sel - py;
    ad  = (d < 0) ? -d : d;
    drive = ga && (ad > DZ) && ((m_state == RET && !bd) || (m_state == TRK && bd));
    wu = drive && (d < 0) && (py > 0);
    wd = drive && (d > 0) && (py < MAXY);
    ns = m_state; nc = 0;
    if (!ga) ns = IDLE;
    else begin
      case (m_state)
        IDLE: ns = bd ? REA : RET;
        RET:  if (bd) ns = REA;
        REA:  if (!bd) ns = RET; else if (m_cnt == RT - 1) ns = TRK; else nc = m_cnt + 1;
        TRK:  if (!bd) ns = RET; else if (ad <= DZ) ns = HLD;
        HLD:  if (!bd) ns = RET; else if (ad > DZ + 1) ns = TRK;
        default: ns = IDLE;
      endcase
    end
`ifdef PONG_AI_AIM_ERROR_EN
    if (ns == REA && m_state != REA) begin
      v = m_lf & 3;
      m_off = (v >= 2) ? v - 4 : v;
    end
    m_lf = ((m_lf << 1) | (((m_lf >> 7) ^ (m_lf >> 5) ^ (m_lf >> 4) ^ (m_lf >> 3)) & 1)) & 255;
`endif
    m_up = (wu && !m_dn) ? 1 : 0;
    m_dn = (wd && !m_up_prev(wu)) ? 1 : 0;
    m_state = ns; m_cnt = nc;
  endtask

  // m_up was already overwritten; recover whether up was high before this edge
  int up_before = 0;
  function automatic bit m_up_prev(bit unused);
    return up_before != 0;
  endfunction

  task automatic cycle();
    @(posedge clock);
    up_before = m_up;
    model_step();
    #1;
    chk("state", int'(ai_state), m_state);
    chk("up",    int'(up),       m_up);
    chk("down",  int'(down),     m_dn);
  endtask

  // Paddle controller stand-in: follow the requests one row per clock
  task automatic follow();
    if (up && paddle_y != 0)        paddle_y = paddle_y - 6'd1;
    else if (down && paddle_y < 63) paddle_y = paddle_y + 6'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset held with the rally active
    reset = 1'b1; game_active = 1'b1; ball_dir_x = 1'b0; ball_y = 6'd15; paddle_y = 6'd12;
    cycle(); cycle();
    chk("rst_state", int'(ai_state), 0);
    chk("rst_out", int'({up, down}), 0);
    reset = 1'b0;
    cycle();
    chk("rel_return", int'(ai_state), RET);

    // Return toward centre
    paddle_y = 6'd20;
    cycle(); xchk("ret_up", int'({up, down}), 2);
    cycle(); xchk("ret_up2", int'({up, down}), 2);
    paddle_y = 6'd13;
    cycle(); xchk("ret_dz13", int'({up, down}), 0);
    paddle_y = 6'd11;
    cycle(); xchk("ret_dz11", int'({up, down}), 0);

    // Reaction delay then tracking
    paddle_y = 6'd12; ball_y = 6'd5; ball_dir_x = 1'b1;
    for (int i = 0; i < RT; i++) begin
      cycle();
      chk("react", int'(ai_state), REA);
      chk("react_out", int'({up, down}), 0);
    end
    cycle(); chk("to_track", int'(ai_state), TRK);
    cycle(); xchk("track_up", int'({up, down}), 2);
    n = 0;
    while (ai_state != 3'(HLD) && n < 30) begin
      follow(); cycle(); n++;
    end
    xchk("hold_reached", int'(ai_state), HLD);
    xchk("hold_py", int'(paddle_y), 3);

    // Hysteresis in HOLD
    paddle_y = 6'd2;
    cycle(); xchk("hold_stay0", int'(ai_state), HLD);
    ball_y = 6'd7;
    cycle(); xchk("hold_stay2", int'(ai_state), HLD);
    ball_y = 6'd8;
    cycle(); xchk("hold_leave", int'(ai_state), TRK);
    cycle(); xchk("hold_down", int'({up, down}), 1);

    // Bottom and top clamps
    ball_y = 6'd29; paddle_y = 6'd23;
    for (int i = 0; i < 4; i++) begin cycle(); xchk("clamp_bot", int'(down), 0); end
    ball_y = 6'd0; paddle_y = 6'd0;
    for (int i = 0; i < 4; i++) begin cycle(); xchk("clamp_top", int'(up), 0); end

    // Direction reversal gap
    ball_y = 6'd5; paddle_y = 6'd10;
    cycle(); cycle(); cycle();
    xchk("rev_up", int'({up, down}), 2);
    ball_y = 6'd40;
    cycle(); xchk("rev_gap", int'({up, down}), 0);
    cycle(); xchk("rev_down", int'({up, down}), 1);

    // Rally ends
    game_active = 1'b0;
    cycle();
    chk("drop_state", int'(ai_state), IDLE);
    chk("drop_out", int'({up, down}), 0);

    // Random play against the model
    game_active = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      follow();
      if ($urandom_range(49) == 0) game_active = ~game_active;
      if ($urandom_range(11) == 0) ball_dir_x = ~ball_dir_x;
      if ($urandom_range(3) == 0) ball_y = 6'($urandom_range(35));
      else if ($urandom_range(1) == 0 && ball_y < 63) ball_y = ball_y + 6'd1;
      else if (ball_y > 0) ball_y = ball_y - 6'd1;
      if ($urandom_range(19) == 0) paddle_y = 6'($urandom_range(40));
      reset = ($urandom_range(499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
